sram_bus_arbiter: RTL

- Shares one SRAM-like master port between two SRAM-like requesters: port 0 = inst, port 1 = data.
- Sits between the CPU core's inst/data SRAM-like ports and a single downstream SRAM-like consumer, such as a unified cache or the AXI bridge.
- Tracks the owner of each outstanding accepted request in an in-order ID FIFO. Routes each m_data_ok/m_rdata back to the correct requester.

---
 rtl/sram_bus_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// ============================================================================
// Module   : sram_bus_arbiter
// Purpose  : Shares one SRAM-like master port between an inst port (0) and a
//            data port (1); an in-order ID FIFO steers each response home.
// Options  : define SRAM_ARB_RR_EN for round-robin arbitration on contention.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bus_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter bit DATA_PRIO   = 1'b1
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,

    output logic        proto_err
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING) + 1;
    localparam int SLOTS = 1 << PTR_W;

    localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(OUTSTANDING);
    localparam logic             PORT_INST = 1'b0;
    localparam logic             PORT_DATA = 1'b1;

    logic [SLOTS-1:0] id_mem_q,   id_mem_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             lock_q,     lock_d;
    logic             lock_port_q, lock_port_d;
    logic             proto_err_q, proto_err_d;

    logic grant;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic head_id;

    assign fifo_full  = (count_q == DEPTH);
    assign fifo_empty = (count_q == '0);

`ifdef SRAM_ARB_RR_EN
    logic rr_q, rr_d;

    always_comb begin
        if (lock_q) begin
            grant = lock_port_q;
        end else if (inst_req && data_req) begin
            grant = rr_q;
        end else begin
            grant = data_req ? PORT_DATA : PORT_INST;
        end
    end

    // Hand the next contended slot to whichever port just lost.
    always_comb begin
        rr_d = rr_q;
        if (push && inst_req && data_req) begin
            rr_d = ~grant;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_q <= PORT_INST;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        if (lock_q) begin
            grant = lock_port_q;
        end else if (inst_req && data_req) begin
            grant = DATA_PRIO;
        end else begin
            grant = data_req ? PORT_DATA : PORT_INST;
        end
    end
`endif

    // Handshake outputs are forced low while reset is held, even if requests are up.
    assign m_req        = (inst_req | data_req) & ~fifo_full & aresetn;
    assign push         = m_req & m_addr_ok;
    assign inst_addr_ok = push & (grant == PORT_INST);
    assign data_addr_ok = push & (grant == PORT_DATA);

    assign m_wr    = (grant == PORT_DATA) ? data_wr    : inst_wr;
    assign m_size  = (grant == PORT_DATA) ? data_size  : inst_size;
    assign m_addr  = (grant == PORT_DATA) ? data_addr  : inst_addr;
    assign m_wdata = (grant == PORT_DATA) ? data_wdata : inst_wdata;

    assign head_id      = id_mem_q[rd_ptr_q];
    assign pop          = m_data_ok & ~fifo_empty & aresetn;
    assign inst_data_ok = pop & (head_id == PORT_INST);
    assign data_data_ok = pop & (head_id == PORT_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    assign proto_err    = proto_err_q;

    always_comb begin
        id_mem_d = id_mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            id_mem_d[wr_ptr_q] = grant;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // The lock pins m_* to a stalled request so a late arrival cannot preempt it.
    always_comb begin
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        if (fifo_full) begin
            lock_d = 1'b0;
        end else if (m_req && !m_addr_ok) begin
            lock_d      = 1'b1;
            lock_port_d = grant;
        end else if (m_addr_ok) begin
            lock_d = 1'b0;
        end
    end

    always_comb begin
        proto_err_d = proto_err_q | (m_data_ok & fifo_empty);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            id_mem_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lock_q      <= 1'b0;
            lock_port_q <= PORT_INST;
            proto_err_q <= 1'b0;
        end else begin
            id_mem_q    <= id_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

`default_nettype wire
